// File: rtl/keycode_history_display.sv
`default_nettype none
// ============================================================================
// Module   : keycode_history_display
// Purpose  : Newest-first keycode history fed by the XT translator handshake,
//            viewed through a scrollable window of active-low 7-segment digits.
// Revision : 1.0  initial release
// ============================================================================
module keycode_history_display #(
    parameter int DEPTH        = 8,
    parameter int DISP_ENTRIES = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          irq,
    input  logic [7:0]                    keycode,
    output logic                          clear_keycode,
    input  logic                          filter_break,
    input  logic                          freeze,
    input  logic                          scroll_up,
    input  logic                          scroll_home,
    input  logic                          clear_history,
    output logic [14*DISP_ENTRIES-1:0]    hex,
    output logic [$clog2(DEPTH+1)-1:0]    entry_count,
    output logic                          overflow
);

    localparam int            CW        = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] c_depth   = CW'(DEPTH);
    localparam logic [CW-1:0] c_disp    = CW'(DISP_ENTRIES);
    localparam logic [0:0]    c_st_idle = 1'b0;
    localparam logic [0:0]    c_st_ack  = 1'b1;

    logic [0:0]    r_state;
    logic [7:0]    r_entries [DEPTH];
    logic [CW-1:0] r_offset;

    logic          w_take;
    logic          w_accept;
    logic [7:0]    w_base [DEPTH];
    logic [7:0]    w_entries_nxt [DEPTH];
    logic [CW-1:0] w_count_base;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_offset_base;
    logic [CW-1:0] w_offset_max;
    logic [CW-1:0] w_offset_nxt;
    logic          w_ovf_nxt;
    logic [14*DISP_ENTRIES-1:0] w_hex_nxt;

    function automatic logic [6:0] f_seg(input logic [3:0] n);
        case (n)
            4'h0: f_seg = 7'h40;
            4'h1: f_seg = 7'h79;
            4'h2: f_seg = 7'h24;
            4'h3: f_seg = 7'h30;
            4'h4: f_seg = 7'h19;
            4'h5: f_seg = 7'h12;
            4'h6: f_seg = 7'h02;
            4'h7: f_seg = 7'h58;
            4'h8: f_seg = 7'h00;
            4'h9: f_seg = 7'h10;
            4'hA: f_seg = 7'h08;
            4'hB: f_seg = 7'h03;
            4'hC: f_seg = 7'h46;
            4'hD: f_seg = 7'h21;
            4'hE: f_seg = 7'h06;
            default: f_seg = 7'h0E;
        endcase
    endfunction

    assign w_take   = (r_state == c_st_idle) && irq;
    assign w_accept = w_take && !freeze && !(filter_break && keycode[7]);

    // clear_history is folded in first so a same-cycle accept lands in an empty buffer
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_base[i] = clear_history ? 8'h00 : r_entries[i];
        end
        w_count_base  = clear_history ? '0 : entry_count;
        w_offset_base = clear_history ? '0 : r_offset;
        w_offset_max  = (w_count_base > c_disp) ? (w_count_base - c_disp) : '0;

        w_entries_nxt = w_base;
        w_count_nxt   = w_count_base;
        w_ovf_nxt     = clear_history ? 1'b0 : overflow;
        w_offset_nxt  = w_offset_base;

        if (w_accept) begin
            for (int i = 1; i < DEPTH; i++) begin
                w_entries_nxt[i] = w_base[i-1];
            end
            w_entries_nxt[0] = keycode;
            if (w_count_base == c_depth) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_count_nxt = w_count_base + CW'(1);
            end
            w_offset_nxt = '0;
        end else if (scroll_home) begin
            w_offset_nxt = '0;
        end else if (scroll_up && (w_offset_base < w_offset_max)) begin
            w_offset_nxt = w_offset_base + CW'(1);
        end
    end

    // Display is built from the current registered history, so it trails by one edge
    always_comb begin
        logic [CW:0] v_idx;
        logic [7:0]  v_sel;
        w_hex_nxt = '1;
        v_idx     = '0;
        v_sel     = 8'h00;
        for (int j = 0; j < DISP_ENTRIES; j++) begin
            v_idx = {1'b0, r_offset} + (CW+1)'(j);
            v_sel = 8'h00;
            for (int k = 0; k < DEPTH; k++) begin
                if (v_idx == (CW+1)'(k)) begin
                    v_sel = r_entries[k];
                end
            end
            if (v_idx < {1'b0, entry_count}) begin
                w_hex_nxt[14*j +: 7]     = f_seg(v_sel[3:0]);
                w_hex_nxt[14*j + 7 +: 7] = f_seg(v_sel[7:4]);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= c_st_idle;
            clear_keycode <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= 8'h00;
            end
            entry_count   <= '0;
            r_offset      <= '0;
            overflow      <= 1'b0;
            hex           <= '1;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (irq) begin
                        clear_keycode <= 1'b1;
                        r_state       <= c_st_ack;
                    end
                end
                default: begin
                    if (!irq) begin
                        clear_keycode <= 1'b0;
                        r_state       <= c_st_idle;
                    end
                end
            endcase
            r_entries   <= w_entries_nxt;
            entry_count <= w_count_nxt;
            overflow    <= w_ovf_nxt;
            r_offset    <= w_offset_nxt;
            hex         <= w_hex_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keycode_history_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_keycode_history_display
// Purpose  : Directed plus randomized checking of two history/display
//            configurations (8x3 and 4x2) against a queue-style reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_keycode_history_display;

    logic        clk = 1'b0;
    logic        reset, irq, filter_break, freeze, scroll_up, scroll_home, clear_history;
    logic [7:0]  keycode;
    logic        clr8, clr4, ovf8, ovf4;
    logic [41:0] hex8;
    logic [27:0] hex4;
    logic [3:0]  cnt8;
    logic [2:0]  cnt4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    keycode_history_display #(.DEPTH(8), .DISP_ENTRIES(3)) u_d8 (
        .clock(clk), .reset(reset), .irq(irq), .keycode(keycode), .clear_keycode(clr8),
        .filter_break(filter_break), .freeze(freeze), .scroll_up(scroll_up),
        .scroll_home(scroll_home), .clear_history(clear_history), .hex(hex8),
        .entry_count(cnt8), .overflow(ovf8)
    );

    keycode_history_display #(.DEPTH(4), .DISP_ENTRIES(2)) u_d4 (
        .clock(clk), .reset(reset), .irq(irq), .keycode(keycode), .clear_keycode(clr4),
        .filter_break(filter_break), .freeze(freeze), .scroll_up(scroll_up),
        .scroll_home(scroll_home), .clear_history(clear_history), .hex(hex4),
        .entry_count(cnt4), .overflow(ovf4)
    );

    // Reference: per configuration, a newest-first list with count, window offset and sticky flag
    logic [6:0]  font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [7:0]  mh [2][8];
    int          mc [2];
    int          mo [2];
    bit          mov [2];
    logic [41:0] mx [2];
    int          md [2] = '{8, 4};
    int          mp [2] = '{3, 2};
    bit          busy;

    function automatic logic [41:0] view(input int n);
        logic [41:0] r = '1;
        for (int j = 0; j < mp[n]; j++) begin
            if (mo[n] + j < mc[n]) begin
                r[14*j +: 7]     = font[mh[n][mo[n]+j][3:0]];
                r[14*j + 7 +: 7] = font[mh[n][mo[n]+j][7:4]];
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        bit take, acc;
        for (int n = 0; n < 2; n++) mx[n] = view(n);
        if (reset) begin
            busy = 0;
            for (int n = 0; n < 2; n++) begin
                for (int i = 0; i < 8; i++) mh[n][i] = 8'h00;
                mc[n] = 0; mo[n] = 0; mov[n] = 0; mx[n] = '1;
            end
        end else begin
            take = irq && !busy;
            if (!busy) busy = irq;
            else if (!irq) busy = 0;
            acc = take && !freeze && !(filter_break && keycode[7]);
            for (int n = 0; n < 2; n++) begin
                if (clear_history) begin
                    for (int i = 0; i < 8; i++) mh[n][i] = 8'h00;
                    mc[n] = 0; mo[n] = 0; mov[n] = 0;
                end
                if (acc) begin
                    if (mc[n] == md[n]) mov[n] = 1;
                    for (int i = md[n] - 1; i > 0; i--) mh[n][i] = mh[n][i-1];
                    mh[n][0] = keycode;
                    mc[n] = (mc[n] < md[n]) ? mc[n] + 1 : md[n];
                    mo[n] = 0;
                end else if (scroll_home) begin
                    mo[n] = 0;
                end else if (scroll_up) begin
                    if (mo[n] < mc[n] - mp[n]) mo[n] = mo[n] + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("clr8", clr8, busy);
        chk("clr4", clr4, busy);
        chk("cnt8", cnt8, mc[0]);
        chk("cnt4", cnt4, mc[1]);
        chk("ovf8", ovf8, mov[0]);
        chk("ovf4", ovf4, mov[1]);
        chk("hex8", hex8, mx[0]);
        chk("hex4", hex4, mx[1][27:0]);
    endtask

    task automatic send(input logic [7:0] kc, input int hold);
        irq = 1'b1; keycode = kc;
        tick();
        chk("ack_rise", clr8, 1);
        repeat (hold) tick();
        irq = 1'b0;
        tick();
        chk("ack_fall", clr8, 0);
    endtask

    task automatic pulse(input int which);
        case (which)
            0: scroll_up = 1'b1;
            1: scroll_home = 1'b1;
            default: clear_history = 1'b1;
        endcase
        tick();
        scroll_up = 1'b0; scroll_home = 1'b0; clear_history = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq = 1'b0; keycode = 8'h00; filter_break = 1'b0; freeze = 1'b0;
        scroll_up = 1'b0; scroll_home = 1'b0; clear_history = 1'b0;
        tick(); tick();
        chk("rst_hex8", hex8, {42{1'b1}});
        chk("rst_cnt8", cnt8, 0);
        chk("rst_clr8", clr8, 0);
        reset = 1'b0;
        tick();

        send(8'h1E, 1);
        chk("first_cnt", cnt8, 1);
        chk("first_lo", hex8[6:0], 7'h06);
        chk("first_hi", hex8[13:7], 7'h79);
        chk("first_blank", hex8[41:14], {28{1'b1}});

        pulse(2);
        filter_break = 1'b1;
        send(8'h1E, 0); send(8'h9E, 2); send(8'h2A, 0);
        chk("filt_cnt", cnt8, 2);
        chk("filt_s0", hex8[13:0], {7'h24, 7'h08});
        chk("filt_s1", hex8[27:14], {7'h79, 7'h06});

        freeze = 1'b1;
        send(8'h1E, 0); send(8'h9E, 1); send(8'h2A, 0);
        chk("frz_cnt", cnt8, 2);
        chk("frz_s0", hex8[13:0], {7'h24, 7'h08});
        freeze = 1'b0; filter_break = 1'b0;

        pulse(2);
        for (int c = 1; c <= 5; c++) send(8'(c), 0);
        chk("d4_cnt", cnt4, 4);
        chk("d4_ovf", ovf4, 1);
        chk("d4_view", hex4, {7'h40, 7'h19, 7'h40, 7'h12});
        chk("d8_ovf", ovf8, 0);
        pulse(2);
        tick();
        chk("clr_cnt4", cnt4, 0);
        chk("clr_ovf4", ovf4, 0);
        chk("clr_hex4", hex4, {28{1'b1}});

        for (int c = 8'h11; c <= 8'h18; c++) send(8'(c), 0);
        repeat (5) pulse(0);
        tick();
        chk("scr5_s0", hex8[13:0], {7'h79, 7'h30});
        pulse(0);
        tick();
        chk("scr6_s0", hex8[13:0], {7'h79, 7'h30});
        pulse(1);
        tick();
        chk("home_s0", hex8[13:0], {7'h79, 7'h00});
        repeat (2) pulse(0);
        scroll_up = 1'b1; irq = 1'b1; keycode = 8'h3C;
        tick();
        scroll_up = 1'b0; irq = 1'b0;
        tick();
        chk("acc_beats_up", hex8[13:0], {7'h30, 7'h46});
        chk("ovf8_set", ovf8, 1);

        irq = 1'b1; keycode = 8'h55;
        tick();
        reset = 1'b1;
        tick();
        chk("rstack_clr", clr8, 0);
        chk("rstack_cnt", cnt8, 0);
        chk("rstack_ovf", ovf8, 0);
        chk("rstack_hex", hex8, {42{1'b1}});
        reset = 1'b0;
        tick();
        chk("retake_clr", clr8, 1);
        chk("retake_cnt", cnt8, 1);
        irq = 1'b0;
        tick(); tick();

        for (int it = 0; it < 120; it++) begin
            case ($urandom_range(0, 6))
                0, 1, 2, 3: begin
                    filter_break = 1'($urandom_range(0, 1));
                    freeze       = ($urandom_range(0, 4) == 0);
                    send(8'($urandom), int'($urandom_range(0, 2)));
                end
                4: pulse(0);
                5: pulse(1);
                default: pulse(($urandom_range(0, 3) == 0) ? 2 : 0);
            endcase
        end
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
